// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one bramctl port between NUM_REQ requesters.
// Each access drives the port for exactly one cycle; read data returns tagged with the requester id.
module bram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [2*NUM_REQ-1:0]  req_mode,
    input  logic [40*NUM_REQ-1:0] req_addr,
    input  logic [40*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  rvalid,
    output logic [IDW-1:0]        rid,
    output logic [39:0]           rdata,
    output logic [39:0]           MemAddr,
    output logic [39:0]           MemDataIn,
    input  logic [39:0]           MemDataOut,
    output logic [1:0]            mode,
    output logic                  RW
);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [2:0]     cnt;
    logic [IDW-1:0] winner;
    logic           found;
    logic [IDW:0]   scan;
    logic [IDW-1:0] next_ptr;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NUM_REQ))
                scan = scan - (IDW+1)'(NUM_REQ);
            if (!found && req[scan[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan[IDW-1:0];
            end
        end
    end

    // A locked owner that still requests keeps the pointer and wins again.
    always_comb begin
        if (req_lock[owner] && req[owner])
            next_ptr = owner;
        else if (owner == IDW'(NUM_REQ-1))
            next_ptr = '0;
        else
            next_ptr = owner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rvalid    <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            MemAddr   <= '0;
            MemDataIn <= '0;
            mode      <= '0;
            RW        <= 1'b1;
        end else begin
            gnt    <= '0;
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        MemAddr   <= req_addr[40*winner +: 40];
                        MemDataIn <= req_wdata[40*winner +: 40];
                        mode      <= req_mode[2*winner +: 2];
                        RW        <= req_rw[winner];
                        gnt       <= NUM_REQ'(1) << winner;
                        owner     <= winner;
                        state     <= ACCESS;
                    end else begin
                        RW <= 1'b1;
                    end
                end
                ACCESS: begin
                    // RW still holds the kind of access bramctl is sampling this cycle.
                    RW <= 1'b1;
                    if (RW) begin
                        cnt   <= 3'(RD_LAT);
                        state <= RWAIT;
                    end else begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                RWAIT: begin
                    if (cnt == 3'd1) begin
                        rdata  <= MemDataOut;
                        rid    <= owner;
                        rvalid <= 1'b1;
                        ptr    <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
